mux_n1_pipe: RTL and testbench

//  Parametrised N:1 word selector with a registered output stage and a valid/ready handshake.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_n1_pipe_if.sv | 29 ++
 rtl/mux_n1_comb.sv | 26 ++
 rtl/mux_n1_pipe.sv | 89 ++++++++
 tb/tb_mux_n1_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants, forwarding-select encoding and width helper for the
// N:1 selector family.
package mux_pkg;

   localparam int DATA_W   = 32;
   localparam int NSRC_FWD = 4;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2,
      FWD_IMM   = 2'd3
   } fwd_sel_e;

   // Select width for n sources; never below 1 so a 1-bit select always exists.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_n1_pipe_if.sv
// Handshake and data bundle between a producer-side master and the
// mux_n1_pipe stage.
interface mux_n1_pipe_if #(
   parameter int WIDTH = mux_pkg::DATA_W,
   parameter int NSRC  = mux_pkg::NSRC_FWD,
   parameter int CNTW  = 8
);

   logic                                    in_valid;
   logic                                    in_ready;
   logic [NSRC*WIDTH-1:0]                   src_data;
   logic [mux_pkg::clog2_min1(NSRC)-1:0]    sel;
   logic                                    out_valid;
   logic                                    out_ready;
   logic [WIDTH-1:0]                        out_data;
   logic                                    sel_err;
   logic [CNTW-1:0]                         stall_cnt;

   modport master (
      output in_valid, src_data, sel, out_ready,
      input  in_ready, out_valid, out_data, sel_err, stall_cnt
   );

   modport slave (
      input  in_valid, src_data, sel, out_ready,
      output in_ready, out_valid, out_data, sel_err, stall_cnt
   );

endinterface

// File: rtl/mux_n1_comb.sv
// Purely combinational indexed word select; an out-of-range index yields
// zero data and raises oor.
module mux_n1_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int NSRC  = NSRC_FWD
) (
   input  logic [NSRC*WIDTH-1:0]          src_data,
   input  logic [clog2_min1(NSRC)-1:0]    sel,
   output logic [WIDTH-1:0]               data,
   output logic                           oor
);

   always_comb begin
      data = '0;
      oor  = 1'b1;
      for (int k = 0; k < NSRC; k++) begin
         if (32'(sel) == k) begin
            data = src_data[k*WIDTH +: WIDTH];
            oor  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 word selector with a registered output stage, valid/ready handshake,
// flush, out-of-range flag and a saturating stall counter.
module mux_n1_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int NSRC  = NSRC_FWD,
   parameter int CNTW  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   mux_n1_pipe_if.slave bus
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_oor;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             sel_err_q,   sel_err_d;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

   logic in_ready;
   logic accept;
   logic stalled;

   mux_n1_comb #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
   ) u_sel (
      .src_data (bus.src_data),
      .sel      (bus.sel),
      .data     (sel_data),
      .oor      (sel_oor)
   );

   assign in_ready = ~out_valid_q | bus.out_ready;
   assign accept   = bus.in_valid & in_ready;
   assign stalled  = out_valid_q & ~bus.out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sel_err_d   = sel_err_q;
      stall_cnt_d = '0;
      if (flush) begin
         // Data is left as-is; only the valid/flag/counter state is dropped.
         out_valid_d = 1'b0;
         sel_err_d   = 1'b0;
      end else begin
         if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            sel_err_d   = sel_oor;
         end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
            sel_err_d   = 1'b0;
         end
         if (stalled) begin
            stall_cnt_d = stall_cnt_q;
            if (stall_cnt_q != {CNTW{1'b1}}) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sel_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sel_err_q   <= sel_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Bench for mux_n1_pipe: three parameterisations (4 sources, 3-bit counter,
// 3 sources) driven by directed and randomized scenarios.
module tb_mux_n1_pipe;

   logic clk;
   logic rst_n;
   logic flush;

   int checks;
   int errors;

   mux_n1_pipe_if #(.WIDTH(32), .NSRC(4), .CNTW(8)) bus_a ();
   mux_n1_pipe_if #(.WIDTH(32), .NSRC(4), .CNTW(3)) bus_b ();
   mux_n1_pipe_if #(.WIDTH(32), .NSRC(3), .CNTW(8)) bus_c ();

   mux_n1_pipe #(.WIDTH(32), .NSRC(4), .CNTW(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a));
   mux_n1_pipe #(.WIDTH(32), .NSRC(4), .CNTW(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b));
   mux_n1_pipe #(.WIDTH(32), .NSRC(3), .CNTW(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; bus_a.sel = '0; bus_a.src_data = '0;
      bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.sel = '0; bus_b.src_data = '0;
      bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b1; bus_c.sel = '0; bus_c.src_data = '0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_a.in_valid  = 1'b1;
         bus_a.out_ready = 1'($urandom_range(0, 1));
         bus_a.sel       = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) bus_a.src_data[k*32 +: 32] = $urandom;
         tick();
      end
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid: got %b expected 0", bus_a.out_valid); end
      checks++; if (bus_a.out_data !== 32'h0) begin errors++;
         $display("FAIL reset_out_data: got %h expected 0", bus_a.out_data); end
      checks++; if (bus_a.stall_cnt !== 8'h0) begin errors++;
         $display("FAIL reset_stall_cnt: got %0d expected 0", bus_a.stall_cnt); end
      checks++; if (bus_a.sel_err !== 1'b0) begin errors++;
         $display("FAIL reset_sel_err: got %b expected 0", bus_a.sel_err); end
      idle_all();
      bus_a.out_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (bus_a.in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready: got %b expected 1", bus_a.in_ready); end
      tick();
      bus_a.out_ready = 1'b1;
   endtask

   task automatic test_select_sweep();
      for (int k = 0; k < 4; k++) bus_a.src_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_a.in_valid = 1'b1;
         bus_a.sel      = 2'(i);
         #1;
         checks++; if (bus_a.in_ready !== 1'b1) begin errors++;
            $display("FAIL sweep_in_ready[%0d]: got %b expected 1", i, bus_a.in_ready); end
         tick();
         checks++; if (bus_a.out_valid !== 1'b1) begin errors++;
            $display("FAIL sweep_valid[%0d]: got %b expected 1", i, bus_a.out_valid); end
         checks++; if (bus_a.out_data !== 32'hA000_0000 + 32'(i)) begin errors++;
            $display("FAIL sweep_data[%0d]: got %h expected %h", i, bus_a.out_data,
                     32'hA000_0000 + 32'(i)); end
      end
      bus_a.in_valid = 1'b0;
      tick();
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL sweep_drain: got %b expected 0", bus_a.out_valid); end
   endtask

   task automatic test_stall_hold();
      logic [31:0] exp;
      for (int k = 0; k < 4; k++) bus_a.src_data[k*32 +: 32] = $urandom;
      exp = bus_a.src_data[2*32 +: 32];
      bus_a.sel       = 2'd2;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b0;
      tick();
      for (int i = 1; i <= 5; i++) begin
         for (int k = 0; k < 4; k++) bus_a.src_data[k*32 +: 32] = $urandom;
         bus_a.sel = 2'($urandom_range(0, 3));
         #1;
         checks++; if (bus_a.in_ready !== 1'b0) begin errors++;
            $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus_a.in_ready); end
         tick();
         checks++; if (bus_a.out_data !== exp) begin errors++;
            $display("FAIL stall_data[%0d]: got %h expected %h", i, bus_a.out_data, exp); end
         checks++; if (bus_a.stall_cnt !== 8'(i)) begin errors++;
            $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, bus_a.stall_cnt, i); end
      end
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      tick();
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL stall_release_valid: got %b expected 0", bus_a.out_valid); end
      checks++; if (bus_a.stall_cnt !== 8'd0) begin errors++;
         $display("FAIL stall_release_cnt: got %0d expected 0", bus_a.stall_cnt); end
   endtask

   task automatic test_saturation();
      int exp;
      bus_b.src_data  = {$urandom, $urandom, $urandom, $urandom};
      bus_b.sel       = 2'd1;
      bus_b.in_valid  = 1'b1;
      bus_b.out_ready = 1'b0;
      tick();
      bus_b.in_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp = (i > 7) ? 7 : i;
         checks++; if (bus_b.stall_cnt !== 3'(exp)) begin errors++;
            $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus_b.stall_cnt, exp); end
      end
      bus_b.out_ready = 1'b1;
      tick();
      checks++; if (bus_b.stall_cnt !== 3'd0) begin errors++;
         $display("FAIL sat_clear: got %0d expected 0", bus_b.stall_cnt); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] w1;
      bus_c.src_data  = {$urandom, $urandom, $urandom};
      w1              = bus_c.src_data[32 +: 32];
      bus_c.out_ready = 1'b1;
      bus_c.in_valid  = 1'b1;
      bus_c.sel       = 2'd3;
      tick();
      checks++; if (bus_c.out_valid !== 1'b1) begin errors++;
         $display("FAIL oor_valid: got %b expected 1", bus_c.out_valid); end
      checks++; if (bus_c.out_data !== 32'h0) begin errors++;
         $display("FAIL oor_data: got %h expected 0", bus_c.out_data); end
      checks++; if (bus_c.sel_err !== 1'b1) begin errors++;
         $display("FAIL oor_err: got %b expected 1", bus_c.sel_err); end
      bus_c.sel = 2'd1;
      tick();
      checks++; if (bus_c.out_data !== w1) begin errors++;
         $display("FAIL oor_legal_data: got %h expected %h", bus_c.out_data, w1); end
      checks++; if (bus_c.sel_err !== 1'b0) begin errors++;
         $display("FAIL oor_legal_err: got %b expected 0", bus_c.sel_err); end
      bus_c.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush_and_reset();
      bus_a.src_data  = {$urandom, $urandom, $urandom, $urandom};
      bus_a.sel       = 2'd1;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b0;
      tick();
      tick();
      flush         = 1'b1;
      bus_a.sel     = 2'd3;
      #1;
      checks++; if (bus_a.in_ready !== 1'b0) begin errors++;
         $display("FAIL flush_in_ready: got %b expected 0", bus_a.in_ready); end
      tick();
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL flush_valid: got %b expected 0", bus_a.out_valid); end
      checks++; if (bus_a.stall_cnt !== 8'd0) begin errors++;
         $display("FAIL flush_cnt: got %0d expected 0", bus_a.stall_cnt); end
      checks++; if (bus_a.sel_err !== 1'b0) begin errors++;
         $display("FAIL flush_err: got %b expected 0", bus_a.sel_err); end
      flush           = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      tick();
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL flush_dropped: got %b expected 0", bus_a.out_valid); end
      // Load a word, stall it, then pull reset between clock edges.
      bus_a.sel       = 2'd0;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b0;
      tick();
      bus_a.in_valid = 1'b0;
      tick();
      tick();
      checks++; if (bus_a.stall_cnt !== 8'd2) begin errors++;
         $display("FAIL midstall_cnt: got %0d expected 2", bus_a.stall_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++;
         $display("FAIL async_rst_valid: got %b expected 0", bus_a.out_valid); end
      checks++; if (bus_a.out_data !== 32'h0) begin errors++;
         $display("FAIL async_rst_data: got %h expected 0", bus_a.out_data); end
      checks++; if (bus_a.stall_cnt !== 8'd0) begin errors++;
         $display("FAIL async_rst_cnt: got %0d expected 0", bus_a.stall_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_a.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_random(input int ncyc);
      logic [31:0] exp_q[$];
      logic [31:0] src[4];
      int          m_cnt;
      int          s;
      logic        exp_rdy;
      logic        iv, orr, fl;
      m_cnt = 0;
      for (int c = 0; c < ncyc; c++) begin
         fl  = ($urandom_range(0, 19) == 0);
         iv  = ($urandom_range(0, 2) != 0);
         orr = ($urandom_range(0, 1) != 0);
         s   = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) begin
            src[k] = $urandom;
            bus_a.src_data[k*32 +: 32] = src[k];
         end
         flush           = fl;
         bus_a.in_valid  = iv;
         bus_a.out_ready = orr;
         bus_a.sel       = 2'(s);
         #1;
         exp_rdy = (exp_q.size() == 0) || orr;
         checks++; if (bus_a.in_ready !== exp_rdy) begin errors++;
            $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, bus_a.in_ready, exp_rdy); end
         checks++; if (bus_a.out_valid !== (exp_q.size() != 0)) begin errors++;
            $display("FAIL rnd_valid[%0d]: got %b expected %b", c, bus_a.out_valid,
                     exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (bus_a.out_data !== exp_q[0]) begin errors++;
               $display("FAIL rnd_data[%0d]: got %h expected %h", c, bus_a.out_data, exp_q[0]); end
            checks++; if (bus_a.sel_err !== 1'b0) begin errors++;
               $display("FAIL rnd_err[%0d]: got %b expected 0", c, bus_a.sel_err); end
         end
         checks++; if (bus_a.stall_cnt !== 8'(m_cnt)) begin errors++;
            $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", c, bus_a.stall_cnt, m_cnt); end
         if (fl) begin
            exp_q.delete();
            m_cnt = 0;
         end else begin
            if (exp_q.size() != 0 && !orr) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            else m_cnt = 0;
            if (exp_q.size() != 0 && orr) void'(exp_q.pop_front());
            if (iv && exp_rdy) exp_q.push_back(src[s]);
         end
         tick();
      end
      idle_all();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_all();
      test_reset();
      test_select_sweep();
      test_stall_hold();
      test_saturation();
      test_out_of_range();
      test_flush_and_reset();
      test_random(400);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
